// File: rtl/ad7264_conversion_sequencer.sv
`timescale 1ns/1ps
// AD7264 frame sequencer for the AquaTux SPI master: drives ss/startSending/DIM and
// deserializes DOMA/DOMB into 14-bit samples. Optional macro: AD7264_SEQ_AUTO_EN (auto_mode).
module ad7264_conversion_sequencer #(
   parameter int CTRL_BITS    = 16,
   parameter int DATA_BITS    = 14,
   parameter int LEAD_BITS    = 2,
   parameter int TX_LATENCY   = 1,
   parameter int RX_LATENCY   = 2,
   parameter int FRAME_BITS   = 32,
   parameter int QUIET_CYCLES = 2
) (
   input  logic                 Clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CTRL_BITS-1:0] ctrl_word,
`ifdef AD7264_SEQ_AUTO_EN
   input  logic                 auto_mode,
`endif
   output logic                 busy,
   output logic                 ss,
   output logic                 startSending,
   output logic                 DIM,
   input  logic                 DOMA,
   input  logic                 DOMB,
   output logic [DATA_BITS-1:0] data_a,
   output logic [DATA_BITS-1:0] data_b,
   output logic                 data_valid,
   output logic [7:0]           sample_count
);

   localparam int CNT_W  = $clog2(FRAME_BITS + 1);
   localparam int QCNT_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0]  CTRL_END = CNT_W'(CTRL_BITS);
   localparam logic [CNT_W-1:0]  TX_FIRST = CNT_W'(TX_LATENCY);
   localparam logic [CNT_W-1:0]  TX_LAST  = CNT_W'(TX_LATENCY + CTRL_BITS - 1);
   localparam logic [CNT_W-1:0]  RX_FIRST = CNT_W'(RX_LATENCY + LEAD_BITS);
   localparam logic [CNT_W-1:0]  RX_LAST  = CNT_W'(RX_LATENCY + LEAD_BITS + DATA_BITS - 1);
   localparam logic [QCNT_W-1:0] QCNT_ONE = QCNT_W'(1);
   localparam logic [QCNT_W-1:0] LAST_Q   = QCNT_W'(QUIET_CYCLES - 1);

   if (FRAME_BITS < RX_LATENCY + LEAD_BITS + DATA_BITS) begin : g_err_rx_window
      $error("FRAME_BITS cannot hold the receive window");
   end
   if (FRAME_BITS < TX_LATENCY + CTRL_BITS) begin : g_err_tx_window
      $error("FRAME_BITS cannot hold the transmit window");
   end
   if (QUIET_CYCLES < 1) begin : g_err_quiet
      $error("QUIET_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_QUIET = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [QCNT_W-1:0]     quiet_cnt_q, quiet_cnt_d;
   logic [CTRL_BITS-1:0]  ctrl_shift_q, ctrl_shift_d;
   logic [DATA_BITS-1:0]  shift_a_q, shift_a_d;
   logic [DATA_BITS-1:0]  shift_b_q, shift_b_d;
   logic [DATA_BITS-1:0]  data_a_q, data_a_d;
   logic [DATA_BITS-1:0]  data_b_q, data_b_d;
   logic [7:0]            sample_cnt_q, sample_cnt_d;
   logic                  data_valid_q, data_valid_d;
   logic                  ss_q, ss_d;
   logic                  busy_q, busy_d;
   logic                  start_sending_q, start_sending_d;
   logic                  dim_q, dim_d;
   logic                  auto_go_s;
   logic [CTRL_BITS-1:0]  ctrl_reload_s;

`ifdef AD7264_SEQ_AUTO_EN
   logic [CTRL_BITS-1:0]  ctrl_lat_q;

   // Keeps the accepted control word so free-running frames can reuse it.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         ctrl_lat_q <= '0;
      end else if ((state_q == ST_IDLE) && start) begin
         ctrl_lat_q <= ctrl_word;
      end else begin
         ctrl_lat_q <= ctrl_lat_q;
      end
   end

   assign auto_go_s     = auto_mode;
   assign ctrl_reload_s = ctrl_lat_q;
`else
   assign auto_go_s     = 1'b0;
   assign ctrl_reload_s = ctrl_word;
`endif

   // Next-state logic; outputs are derived from the next state so they register cleanly.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      quiet_cnt_d  = quiet_cnt_q;
      ctrl_shift_d = ctrl_shift_q;
      shift_a_d    = shift_a_q;
      shift_b_d    = shift_b_q;
      data_a_d     = data_a_q;
      data_b_d     = data_b_q;
      sample_cnt_d = sample_cnt_q;
      data_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_FRAME;
               bit_cnt_d    = '0;
               ctrl_shift_d = ctrl_word;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FRAME: begin
            ctrl_shift_d = {ctrl_shift_q[CTRL_BITS-2:0], 1'b0};
            if ((bit_cnt_q >= RX_FIRST) && (bit_cnt_q <= RX_LAST)) begin
               shift_a_d = {shift_a_q[DATA_BITS-2:0], DOMA};
               shift_b_d = {shift_b_q[DATA_BITS-2:0], DOMB};
            end else begin
               shift_a_d = shift_a_q;
               shift_b_d = shift_b_q;
            end
            if (bit_cnt_q == LAST_BIT) begin
               state_d      = ST_QUIET;
               quiet_cnt_d  = '0;
               data_a_d     = shift_a_q;
               data_b_d     = shift_b_q;
               sample_cnt_d = sample_cnt_q + 8'd1;
               data_valid_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
         end
         ST_QUIET: begin
            if (quiet_cnt_q == LAST_Q) begin
               if (auto_go_s) begin
                  state_d      = ST_FRAME;
                  bit_cnt_d    = '0;
                  ctrl_shift_d = ctrl_reload_s;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               quiet_cnt_d = quiet_cnt_q + QCNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ss_d   = (state_d == ST_FRAME);
      busy_d = (state_d != ST_IDLE);
      if ((state_d == ST_FRAME) && (bit_cnt_d < CTRL_END)) begin
         dim_d = ctrl_shift_d[CTRL_BITS-1];
      end else begin
         dim_d = 1'b0;
      end
      if ((state_d == ST_FRAME) && (bit_cnt_d >= TX_FIRST) && (bit_cnt_d <= TX_LAST)) begin
         start_sending_d = 1'b1;
      end else begin
         start_sending_d = 1'b0;
      end
   end

   // State, datapath and output registers; reset clears everything at once.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         bit_cnt_q       <= '0;
         quiet_cnt_q     <= '0;
         ctrl_shift_q    <= '0;
         shift_a_q       <= '0;
         shift_b_q       <= '0;
         data_a_q        <= '0;
         data_b_q        <= '0;
         sample_cnt_q    <= 8'd0;
         data_valid_q    <= 1'b0;
         ss_q            <= 1'b0;
         busy_q          <= 1'b0;
         start_sending_q <= 1'b0;
         dim_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         quiet_cnt_q     <= quiet_cnt_d;
         ctrl_shift_q    <= ctrl_shift_d;
         shift_a_q       <= shift_a_d;
         shift_b_q       <= shift_b_d;
         data_a_q        <= data_a_d;
         data_b_q        <= data_b_d;
         sample_cnt_q    <= sample_cnt_d;
         data_valid_q    <= data_valid_d;
         ss_q            <= ss_d;
         busy_q          <= busy_d;
         start_sending_q <= start_sending_d;
         dim_q           <= dim_d;
      end
   end

   assign busy         = busy_q;
   assign ss           = ss_q;
   assign startSending = start_sending_q;
   assign DIM          = dim_q;
   assign data_a       = data_a_q;
   assign data_b       = data_b_q;
   assign data_valid   = data_valid_q;
   assign sample_count = sample_cnt_q;

endmodule

// File: tb/tb_ad7264_conversion_sequencer.sv
`timescale 1ns/1ps
// Directed bench for ad7264_conversion_sequencer: drives frames with an ADC stand-in on
// DOMA/DOMB and compares serial patterns, samples and counters against hand-derived values.
module tb_ad7264_conversion_sequencer;

   logic        Clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] ctrl_word;
   logic        auto_mode;
   logic        busy, ss, startSending, DIM;
   logic        DOMA, DOMB;
   logic [13:0] data_a, data_b;
   logic        data_valid;
   logic [7:0]  sample_count;

   int n_vec = 0;
   int n_err = 0;
   int exp_cnt = 0;

   ad7264_conversion_sequencer dut (
      .Clk          (Clk),
      .reset        (reset),
      .start        (start),
      .ctrl_word    (ctrl_word),
`ifdef AD7264_SEQ_AUTO_EN
      .auto_mode    (auto_mode),
`endif
      .busy         (busy),
      .ss           (ss),
      .startSending (startSending),
      .DIM          (DIM),
      .DOMA         (DOMA),
      .DOMB         (DOMB),
      .data_a       (data_a),
      .data_b       (data_b),
      .data_valid   (data_valid),
      .sample_count (sample_count)
   );

   always #5 Clk = ~Clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Runs one frame from the negedge before it starts; returns at the first QUIET-cycle negedge.
   task automatic do_frame(input logic [15:0] cw, input logic [13:0] da, input logic [13:0] db,
                           input bit drive_start, input bit keep_start, input int exp_gap,
                           input int glitch_k);
      logic [31:0] dim_pat, ss_pat, sse_pat;
      int gap, busy_n;
      dim_pat = '0; ss_pat = '0; sse_pat = '0; busy_n = 0; gap = 0;
      if (drive_start) begin
         start = 1'b1;
         ctrl_word = cw;
      end
      while (ss !== 1'b1 && gap < 100) begin
         @(negedge Clk);
         gap++;
      end
      check_value("frame_start", {31'd0, ss}, 32'd1);
      if (exp_gap >= 0) check_value("ss_low_gap", gap, exp_gap);
      if (!keep_start) start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         dim_pat[31-k] = DIM;
         ss_pat[31-k]  = ss;
         sse_pat[31-k] = startSending;
         busy_n += (busy === 1'b1) ? 1 : 0;
         if (k == glitch_k) begin
            start = 1'b1;
            ctrl_word = 16'hFFFF;
         end else if (glitch_k >= 0 && k == glitch_k + 1) begin
            start = 1'b0;
         end
         DOMA = (k >= 4 && k <= 17) ? da[17-k] : 1'b0;
         DOMB = (k >= 4 && k <= 17) ? db[17-k] : 1'b0;
         @(negedge Clk);
      end
      DOMA = 1'b0;
      DOMB = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      check_value("dim_pattern", dim_pat, {cw, 16'h0000});
      check_value("ss_pattern", ss_pat, 32'hFFFF_FFFF);
      check_value("startSending_pattern", sse_pat, 32'h7FFF_8000);
      check_value("busy_in_frame", busy_n, 32);
      check_value("quiet_ss_busy_dv", {29'd0, ss, busy, data_valid}, 32'd3);
      check_value("data_a", {18'd0, data_a}, {18'd0, da});
      check_value("data_b", {18'd0, data_b}, {18'd0, db});
      check_value("sample_count", {24'd0, sample_count}, exp_cnt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      logic ss_seen;
      reset = 1'b1; start = 1'b0; ctrl_word = 16'h0000;
      DOMA = 1'b0; DOMB = 1'b0; auto_mode = 1'b0;

      @(negedge Clk);
      check_value("reset_outputs", {27'd0, ss, startSending, DIM, busy, data_valid}, 32'd0);
      check_value("reset_data", {4'd0, data_a, data_b}, 32'd0);
      check_value("reset_count", {24'd0, sample_count}, 32'd0);
      repeat (2) @(negedge Clk);
      reset = 1'b0;
      @(negedge Clk);

      // single frame, busy spans 32 frame + 2 quiet cycles
      do_frame(16'hA5C3, 14'h2ABC, 14'h1357, 1'b1, 1'b0, 1, -1);
      @(negedge Clk);
      check_value("quiet2_busy_dv", {30'd0, busy, data_valid}, 32'd2);
      @(negedge Clk);
      check_value("idle_busy", {31'd0, busy}, 32'd0);
      check_value("data_a_hold", {18'd0, data_a}, 32'h2ABC);

      // start held: three frames, ss low 3 cycles between them
      do_frame(16'h1234, 14'h0001, 14'h3FFF, 1'b1, 1'b1, 1, -1);
      do_frame(16'h1234, 14'h1555, 14'h2AAA, 1'b1, 1'b1, 3, -1);
      do_frame(16'h1234, 14'h3FFE, 14'h0000, 1'b1, 1'b0, 3, -1);
      repeat (2) @(negedge Clk);

      // start/ctrl_word disturbed mid-frame must be ignored
      do_frame(16'hA5C3, 14'h0ABC, 14'h1111, 1'b1, 1'b0, 1, 8);
      ss_seen = 1'b0;
      repeat (6) begin
         @(negedge Clk);
         ss_seen = ss_seen | ss;
      end
      check_value("no_extra_frame", {31'd0, ss_seen}, 32'd0);
      check_value("idle_after_glitch", {31'd0, busy}, 32'd0);

      // asynchronous reset at bit_cnt 10
      start = 1'b1; ctrl_word = 16'hA5C3;
      @(negedge Clk);
      start = 1'b0;
      repeat (10) @(negedge Clk);
      check_value("pre_reset_ss_sse", {30'd0, ss, startSending}, 32'd3);
      reset = 1'b1;
      #1;
      check_value("async_reset_outputs", {27'd0, ss, startSending, DIM, busy, data_valid}, 32'd0);
      check_value("async_reset_data_a", {18'd0, data_a}, 32'd0);
      check_value("async_reset_count", {24'd0, sample_count}, 32'd0);
      exp_cnt = 0;
      @(negedge Clk);
      reset = 1'b0;
      @(negedge Clk);
      check_value("no_dv_after_abort", {30'd0, data_valid, busy}, 32'd0);
      do_frame(16'hA5C3, 14'h2ABC, 14'h1357, 1'b1, 1'b0, 1, -1);
      repeat (2) @(negedge Clk);

      // 256 back-to-back frames wrap sample_count to 0
      reset = 1'b1;
      @(negedge Clk);
      reset = 1'b0;
      exp_cnt = 0;
      @(negedge Clk);
      for (int i = 0; i < 256; i++) begin
         do_frame(16'(i * 771 + 5), 14'(i * 37), 14'(16383 - i), 1'b1, (i < 255),
                  (i == 0) ? 1 : 3, -1);
         if (i == 254) check_value("count_255", {24'd0, sample_count}, 32'd255);
      end
      check_value("wrap_to_zero", {24'd0, sample_count}, 32'd0);
      repeat (2) @(negedge Clk);

`ifdef AD7264_SEQ_AUTO_EN
      auto_mode = 1'b1;
      do_frame(16'h5A3C, 14'h0F0F, 14'h30F0, 1'b1, 1'b0, 1, -1);
      ctrl_word = 16'h0000;
      do_frame(16'h5A3C, 14'h1234, 14'h0321, 1'b0, 1'b0, 2, -1);
      do_frame(16'h5A3C, 14'h2222, 14'h0444, 1'b0, 1'b0, 2, -1);
      auto_mode = 1'b0;
      repeat (2) @(negedge Clk);
      check_value("auto_stop_idle", {30'd0, ss, busy}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
